// File: rtl/frame_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_sequencer
// Brief    : Assembles one configuration frame from a header + payload word
//            stream and writes it to the tile array with one frame strobe.
// Revision : 1.0 - initial release
// ============================================================================
module frame_config_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 8
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [31:0]                               in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData,
    output logic [MaxFramesPerCol*NumberOfCols-1:0]   FrameStrobe,
    output logic                                      busy,
    output logic [15:0]                               frames_done,
    output logic                                      err_sync,
    output logic                                      err_addr
);

    localparam int c_row_w    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int c_strobes  = MaxFramesPerCol * NumberOfCols;
    localparam int c_idx_w    = (c_strobes > 1) ? $clog2(c_strobes) : 1;
    localparam int c_fd_w     = FrameBitsPerRow * NumberOfRows;
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(NumberOfRows - 1);
    localparam logic [7:0]         c_sync     = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SKIP   = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_sync_ok;
    logic                 w_addr_ok;
    logic                 w_last_row;
    logic [7:0]           w_col;
    logic [7:0]           w_frame;
    logic [c_row_w-1:0]   r_row;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_fd_w-1:0]    r_frame_data;
    logic [15:0]          r_frames_done;
    logic                 r_err_sync;
    logic                 r_err_addr;

    // One stream word per row; the datapath is not defined for other widths.
    generate
        if (FrameBitsPerRow != 32) begin : g_width_check
            $error("frame_config_sequencer: FrameBitsPerRow must be 32");
        end
    endgenerate

    assign w_col      = in_data[23:16];
    assign w_frame    = in_data[15:8];
    assign w_sync_ok  = (in_data[31:24] == c_sync);
    assign w_addr_ok  = (32'(w_col) < 32'(NumberOfCols)) &&
                        (32'(w_frame) < 32'(MaxFramesPerCol));
    assign w_last_row = (r_row == c_last_row);

    // Ready is gated by RST so the source never sees a handshake during reset.
    always_comb begin
        w_ready = 1'b0;
        if (!RST) begin
            w_ready = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                      (r_state == S_SKIP);
        end
    end

    assign w_accept = in_valid && w_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_sync_ok) begin
                    w_state_nxt = w_addr_ok ? S_LOAD : S_SKIP;
                end
            end
            S_LOAD: begin
                if (w_accept && w_last_row) begin
                    w_state_nxt = S_STROBE;
                end
            end
            S_SKIP: begin
                if (w_accept && w_last_row) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STROBE: w_state_nxt = S_HOLD;
            S_HOLD:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_row         <= '0;
            r_idx         <= '0;
            r_frame_data  <= '0;
            r_frames_done <= 16'd0;
            r_err_sync    <= 1'b0;
            r_err_addr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_row <= '0;
                        if (!w_sync_ok) begin
                            r_err_sync <= 1'b1;
                        end else if (!w_addr_ok) begin
                            r_err_addr <= 1'b1;
                        end else begin
                            r_idx <= c_idx_w'(32'(w_col) * MaxFramesPerCol + 32'(w_frame));
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_frame_data[r_row*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
                        r_row <= r_row + 1'b1;
                    end
                end
                S_SKIP: begin
                    if (w_accept) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                S_STROBE: r_frames_done <= r_frames_done + 16'd1;
                default: ;
            endcase
        end
    end

    // Strobe decode straight from state so it can never outlive STROBE.
    generate
        for (genvar gi = 0; gi < c_strobes; gi++) begin : g_strobe
            assign FrameStrobe[gi] = (r_state == S_STROBE) &&
                                     (r_idx == c_idx_w'(gi));
        end
    endgenerate

    assign in_ready    = w_ready;
    assign FrameData   = r_frame_data;
    assign busy        = (r_state != S_IDLE);
    assign frames_done = r_frames_done;
    assign err_sync    = r_err_sync;
    assign err_addr    = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_frame_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_config_sequencer
// Brief    : Self-checking bench; a stream-parsing reference model predicts
//            strobes, frame contents, counters and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_config_sequencer;

    localparam int MF  = 20;
    localparam int FB  = 32;
    localparam int NR  = 16;
    localparam int NC  = 8;
    localparam int FDW = FB * NR;
    localparam int FSW = MF * NC;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [31:0]     in_data = 32'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [FDW-1:0]  FrameData;
    logic [FSW-1:0]  FrameStrobe;
    logic            busy;
    logic [15:0]     frames_done;
    logic            err_sync;
    logic            err_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_low = 0;

    frame_config_sequencer #(
        .MaxFramesPerCol(MF),
        .FrameBitsPerRow(FB),
        .NumberOfRows   (NR),
        .NumberOfCols   (NC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .busy       (busy),
        .frames_done(frames_done),
        .err_sync   (err_sync),
        .err_addr   (err_addr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int cyc; int idx; logic [FDW-1:0] data; } exp_t;
    typedef struct { int cyc; logic [FSW-1:0] strobe; logic [FDW-1:0] data; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    obs_t mon;

    // Observation only: record every cycle with any strobe bit high.
    always @(negedge CLK) begin
        if (FrameStrobe !== '0) begin
            mon.cyc    = cyc;
            mon.strobe = FrameStrobe;
            mon.data   = FrameData;
            obs_q.push_back(mon);
        end
        if (!RST && !in_ready) ready_low++;
    end

    // Reference model: a word-by-word parser of the accepted stream.
    int          m_mode;   // 0 waiting for header, 1 collecting payload, 2 discarding
    int          m_row;
    int          m_idx;
    logic [31:0] m_rows[NR];
    logic [15:0] m_done;
    logic        m_esync;
    logic        m_eaddr;

    function automatic logic [FDW-1:0] m_frame();
        logic [FDW-1:0] v;
        for (int k = 0; k < NR; k++) v[k*FB +: FB] = m_rows[k];
        return v;
    endfunction

    function automatic int strobe_bit(input logic [FSW-1:0] v);
        int n = 0;
        int b = -1;
        for (int i = 0; i < FSW; i++) if (v[i] === 1'b1) begin n++; b = i; end
        return (n == 1) ? b : -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_row = 0; m_idx = 0; m_done = 16'd0;
        m_esync = 1'b0; m_eaddr = 1'b0;
        for (int k = 0; k < NR; k++) m_rows[k] = 32'd0;
    endtask

    task automatic model_accept(input logic [31:0] w, input int acyc);
        exp_t e;
        int col;
        int fr;
        col = int'(w[23:16]);
        fr  = int'(w[15:8]);
        if (m_mode == 0) begin
            if (w[31:24] != 8'hA5) m_esync = 1'b1;
            else if (col >= NC || fr >= MF) begin m_eaddr = 1'b1; m_mode = 2; m_row = 0; end
            else begin m_idx = col * MF + fr; m_mode = 1; m_row = 0; end
        end else if (m_mode == 1) begin
            m_rows[m_row] = w;
            m_row++;
            if (m_row == NR) begin
                e.cyc = acyc + 1; e.idx = m_idx; e.data = m_frame();
                exp_q.push_back(e);
                m_done = m_done + 16'd1;
                m_mode = 0;
            end
        end else begin
            m_row++;
            if (m_row == NR) m_mode = 0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, output int acc);
        int n;
        n = 0;
        acc = -1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge CLK);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 40) break;
        end
        if (n > 40) begin
            checks++; failures++;
            $display("FAIL accept_timeout word=%h waited=%0d required_accept_within=40", w, n);
            @(posedge CLK); #1;
            in_valid = 1'b0;
        end else begin
            acc = cyc;
            @(posedge CLK); #1;
            in_valid = 1'b0;
            model_accept(w, acc);
        end
    endtask

    task automatic send_frame(input logic [7:0] col, input logic [7:0] fr, input logic [31:0] base,
                              input bit rnd, input int stall_row, input int stall_len,
                              output int hdr_cyc);
        int a;
        send_word({8'hA5, col, fr, 8'h00}, 0, hdr_cyc);
        for (int k = 0; k < NR; k++)
            send_word(rnd ? $urandom : base + 32'(k), (k == stall_row) ? stall_len : 0, a);
    endtask

    task automatic settle();
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        ready_low = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", in_ready); end
        checks++; if (FrameData !== '0) begin failures++; $display("FAIL reset_framedata got nonzero want=0"); end
        checks++; if (FrameStrobe !== '0) begin failures++; $display("FAIL reset_strobe got nonzero want=0"); end
        checks++; if (frames_done !== 16'd0) begin failures++; $display("FAIL reset_frames_done got=%0d want=0", frames_done); end
        checks++; if ({err_sync, err_addr, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {err_sync, err_addr, busy}); end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
        model_reset();
        @(posedge CLK); #1;
        clear_obs();
    endtask

    task automatic test_nominal();
        int hc;
        logic [FDW-1:0] want;
        obs_t o;
        clear_obs();
        for (int k = 0; k < NR; k++) want[k*FB +: FB] = 32'h1000 + 32'(k);
        send_frame(8'd2, 8'd5, 32'h1000, 1'b0, -1, 0, hc);
        settle();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL nominal_strobe_count got=%0d want=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (strobe_bit(o.strobe) != 45) begin failures++; $display("FAIL nominal_strobe_bit got=%0d want=45", strobe_bit(o.strobe)); end
            checks++; if (o.cyc != hc + NR + 1) begin failures++; $display("FAIL nominal_strobe_cycle got=%0d want=%0d", o.cyc, hc + NR + 1); end
            checks++; if (o.data !== want) begin failures++; $display("FAIL nominal_data_at_strobe got mismatching rows want=0x1000+k"); end
        end
        checks++; if (FrameData !== want) begin failures++; $display("FAIL nominal_data_idle got mismatching rows want=0x1000+k"); end
        checks++; if (frames_done !== 16'd1) begin failures++; $display("FAIL nominal_frames_done got=%0d want=1", frames_done); end
        checks++; if (ready_low != 2) begin failures++; $display("FAIL nominal_ready_low got=%0d want=2", ready_low); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nominal_busy_idle got=%b want=0", busy); end
    endtask

    task automatic test_stall();
        int hc;
        logic [FDW-1:0] want;
        obs_t o;
        clear_obs();
        for (int k = 0; k < NR; k++) want[k*FB +: FB] = 32'h1000 + 32'(k);
        send_frame(8'd2, 8'd5, 32'h1000, 1'b0, 8, 5, hc);
        settle();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL stall_strobe_count got=%0d want=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (strobe_bit(o.strobe) != 45) begin failures++; $display("FAIL stall_strobe_bit got=%0d want=45", strobe_bit(o.strobe)); end
            checks++; if (o.cyc != hc + NR + 1 + 5) begin failures++; $display("FAIL stall_strobe_cycle got=%0d want=%0d", o.cyc, hc + NR + 6); end
        end
        checks++; if (FrameData !== want) begin failures++; $display("FAIL stall_data got mismatching rows want=0x1000+k"); end
        checks++; if (frames_done !== 16'd2) begin failures++; $display("FAIL stall_frames_done got=%0d want=2", frames_done); end
    endtask

    task automatic test_bad_sync();
        int bc;
        int hc;
        logic [FDW-1:0] want;
        obs_t o;
        clear_obs();
        for (int k = 0; k < NR; k++) want[k*FB +: FB] = 32'h2000 + 32'(k);
        send_word(32'h5A020500, 0, bc);
        send_frame(8'd2, 8'd5, 32'h2000, 1'b0, -1, 0, hc);
        settle();
        checks++; if (err_sync !== 1'b1 || err_addr !== 1'b0) begin failures++; $display("FAIL badsync_flags got=%b%b want=10", err_sync, err_addr); end
        checks++; if (hc != bc + 1) begin failures++; $display("FAIL badsync_discard_next_accept got=%0d want=%0d", hc, bc + 1); end
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL badsync_strobe_count got=%0d want=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (strobe_bit(o.strobe) != 45 || o.cyc != hc + NR + 1) begin failures++; $display("FAIL badsync_strobe got bit=%0d cyc=%0d want bit=45 cyc=%0d", strobe_bit(o.strobe), o.cyc, hc + NR + 1); end
        end
        checks++; if (FrameData !== want) begin failures++; $display("FAIL badsync_data got mismatching rows want=0x2000+k"); end
        checks++; if (frames_done !== 16'd3) begin failures++; $display("FAIL badsync_frames_done got=%0d want=3", frames_done); end
    endtask

    task automatic test_bad_addr();
        int a;
        int hc;
        obs_t o;
        clear_obs();
        send_word(32'hA5080000, 0, a);
        for (int k = 0; k < NR; k++) send_word($urandom, 0, a);
        send_word(32'hA5001400, 0, a);
        for (int k = 0; k < NR; k++) send_word($urandom, 0, a);
        settle();
        checks++; if (err_addr !== 1'b1) begin failures++; $display("FAIL badaddr_flag got=%b want=1", err_addr); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL badaddr_no_strobe got=%0d want=0", obs_q.size()); end
        checks++; if (FrameData !== m_frame()) begin failures++; $display("FAIL badaddr_data_kept got changed want=previous frame"); end
        checks++; if (frames_done !== 16'd3) begin failures++; $display("FAIL badaddr_frames_done got=%0d want=3", frames_done); end
        clear_obs();
        send_frame(8'd7, 8'd19, 32'd0, 1'b1, -1, 0, hc);
        settle();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL badaddr_recover_count got=%0d want=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (strobe_bit(o.strobe) != 159 || o.data !== m_frame()) begin failures++; $display("FAIL badaddr_recover_strobe got bit=%0d want bit=159", strobe_bit(o.strobe)); end
        end
    endtask

    task automatic test_back_to_back();
        int h0;
        int h1;
        logic [15:0] d0;
        obs_t o0;
        obs_t o1;
        exp_t e1;
        clear_obs();
        d0 = m_done;
        send_frame(8'd0, 8'd0, 32'd0, 1'b1, -1, 0, h0);
        send_frame(8'd7, 8'd19, 32'd0, 1'b1, -1, 0, h1);
        settle();
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL b2b_strobe_count got=%0d want=2", obs_q.size()); end
        if (obs_q.size() == 2 && exp_q.size() == 2) begin
            o0 = obs_q.pop_front(); o1 = obs_q.pop_front();
            void'(exp_q.pop_front()); e1 = exp_q.pop_front();
            checks++; if (strobe_bit(o0.strobe) != 0 || strobe_bit(o1.strobe) != 159) begin failures++; $display("FAIL b2b_strobe_bits got=%0d,%0d want=0,159", strobe_bit(o0.strobe), strobe_bit(o1.strobe)); end
            checks++; if (o1.cyc - o0.cyc != 1 + NR + 2) begin failures++; $display("FAIL b2b_period got=%0d want=%0d", o1.cyc - o0.cyc, 1 + NR + 2); end
            checks++; if (o1.data !== e1.data) begin failures++; $display("FAIL b2b_second_data got mismatching rows want=model frame"); end
        end
        checks++; if (frames_done !== d0 + 16'd2) begin failures++; $display("FAIL b2b_frames_done got=%0d want=%0d", frames_done, d0 + 16'd2); end
    endtask

    task automatic test_reset_mid_load();
        int a;
        int hc;
        obs_t o;
        clear_obs();
        send_word(32'hA5030400, 0, a);
        for (int k = 0; k <= 10; k++) send_word($urandom, 0, a);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_in_reset got=%b want=0", in_ready); end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after got=%b want=1", in_ready); end
        checks++; if (FrameData !== '0) begin failures++; $display("FAIL midrst_framedata got nonzero want=0"); end
        checks++; if (frames_done !== 16'd0 || err_sync !== 1'b0 || err_addr !== 1'b0) begin failures++; $display("FAIL midrst_counters got done=%0d es=%b ea=%b want=0,0,0", frames_done, err_sync, err_addr); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_no_strobe got=%0d want=0", obs_q.size()); end
        @(posedge CLK); #1;
        clear_obs();
        send_frame(8'd3, 8'd4, 32'd0, 1'b1, -1, 0, hc);
        settle();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL midrst_new_frame_count got=%0d want=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (strobe_bit(o.strobe) != 64 || o.data !== m_frame() || o.cyc != hc + NR + 1) begin failures++; $display("FAIL midrst_new_frame got bit=%0d cyc=%0d want bit=64 cyc=%0d", strobe_bit(o.strobe), o.cyc, hc + NR + 1); end
        end
        checks++; if (frames_done !== 16'd1) begin failures++; $display("FAIL midrst_new_frames_done got=%0d want=1", frames_done); end
    endtask

    task automatic test_random();
        int a;
        int kind;
        int nexp;
        logic [7:0] sb;
        exp_t e;
        obs_t o;
        clear_obs();
        for (int f = 0; f < 12; f++) begin
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                sb = 8'($urandom_range(0, 255));
                if (sb == 8'hA5) sb = 8'h00;
                send_word({sb, 24'($urandom)}, $urandom_range(0, 2), a);
            end else begin
                if (kind == 1)
                    send_word({8'hA5, 8'($urandom_range(NC, 255)), 8'($urandom_range(0, 255)), 8'($urandom)}, 0, a);
                else if (kind == 2)
                    send_word({8'hA5, 8'($urandom_range(0, NC - 1)), 8'($urandom_range(MF, 255)), 8'($urandom)}, 0, a);
                else
                    send_word({8'hA5, 8'($urandom_range(0, NC - 1)), 8'($urandom_range(0, MF - 1)), 8'($urandom)}, $urandom_range(0, 2), a);
                for (int k = 0; k < NR; k++)
                    send_word($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, a);
            end
        end
        settle();
        nexp = exp_q.size();
        checks++; if (obs_q.size() != nexp) begin failures++; $display("FAIL rand_strobe_count got=%0d want=%0d", obs_q.size(), nexp); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (strobe_bit(o.strobe) != e.idx || o.cyc != e.cyc || o.data !== e.data) begin
                failures++;
                $display("FAIL rand_strobe got bit=%0d cyc=%0d want bit=%0d cyc=%0d", strobe_bit(o.strobe), o.cyc, e.idx, e.cyc);
            end
        end
        checks++; if (frames_done !== m_done) begin failures++; $display("FAIL rand_frames_done got=%0d want=%0d", frames_done, m_done); end
        checks++; if (err_sync !== m_esync || err_addr !== m_eaddr) begin failures++; $display("FAIL rand_err_flags got=%b%b want=%b%b", err_sync, err_addr, m_esync, m_eaddr); end
        checks++; if (FrameData !== m_frame()) begin failures++; $display("FAIL rand_framedata got mismatching rows want=model frame"); end
        checks++; if (ready_low != 2 * nexp) begin failures++; $display("FAIL rand_ready_low got=%0d want=%0d", ready_low, 2 * nexp); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_stall();
        test_bad_sync();
        test_bad_addr();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
